// File: rtl/tnn_infer_sequencer_pkg.sv
// Shared types and size derivations for the TNN inference sequencer.
package tnn_infer_sequencer_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    // Core cycles from the first cycle out of restart until the prediction is valid.
    function automatic int unsigned calc_latency(input int unsigned feat_cnt,
                                                 input int unsigned hidden_cnt);
        return feat_cnt + hidden_cnt;
    endfunction

    function automatic int unsigned calc_pred_w(input int unsigned class_cnt);
        return (class_cnt > 1) ? $clog2(class_cnt) : 1;
    endfunction

endpackage

// File: rtl/tnn_result_reg.sv
// Result register: holds one captured prediction until the consumer takes it,
// and counts completed inferences.
module tnn_result_reg
    import tnn_infer_sequencer_pkg::*;
#(
    parameter int unsigned PRED_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_capture,
    input  logic [PRED_W-1:0]  i_pred,
    input  logic               i_out_ready,
    output logic               o_valid,
    output logic [PRED_W-1:0]  o_pred,
    output logic [COUNT_W-1:0] o_infer_count,
    output logic               o_free_c
);

    logic               r_valid;
    logic [PRED_W-1:0]  r_pred;
    logic [COUNT_W-1:0] r_infer_count;

    // A capture wins over a consume, so a same-cycle handoff keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_pred        <= '0;
            r_infer_count <= '0;
        end else if (i_capture) begin
            r_valid       <= 1'b1;
            r_pred        <= i_pred;
            r_infer_count <= r_infer_count + COUNT_W'(1);
        end else if (r_valid && i_out_ready) begin
            r_valid       <= 1'b0;
        end
    end

    assign o_free_c      = !r_valid || i_out_ready;
    assign o_valid       = r_valid;
    assign o_pred        = r_pred;
    assign o_infer_count = r_infer_count;

endmodule

// File: rtl/tnn_infer_sequencer.sv
// Sequences one sample at a time through an external TNN core: latch, restart
// the core, wait out its latency, then hand the prediction to the result register.
module tnn_infer_sequencer
    import tnn_infer_sequencer_pkg::*;
#(
    parameter  int unsigned FEAT_CNT   = 12,
    parameter  int unsigned HIDDEN_CNT = 40,
    parameter  int unsigned FEAT_BITS  = 4,
    parameter  int unsigned CLASS_CNT  = 6,
    localparam int unsigned PRED_W     = calc_pred_w(CLASS_CNT),
    localparam int unsigned DATA_W     = FEAT_BITS * FEAT_CNT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic [DATA_W-1:0]  core_data,
    output logic               core_rst,
    input  logic [PRED_W-1:0]  core_prediction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PRED_W-1:0]  out_pred,
    output logic               busy,
    output logic [COUNT_W-1:0] infer_count
);

    localparam int unsigned LATENCY = calc_latency(FEAT_CNT, HIDDEN_CNT);
    localparam int unsigned CNT_W   = $clog2(LATENCY + 1);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] r_core_data;
    logic              r_in_ready;
    logic              r_core_rst;
    logic              r_busy;
    logic              w_accept;
    logic              w_capture;
    logic              w_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_core_data <= '0;
            r_in_ready  <= 1'b0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_accept) begin
                r_core_data <= in_data;
            end
            // Status outputs are registered decodes of the state being entered.
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_core_rst  <= (w_state_nxt == ST_CLEAR);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Stops at LATENCY, which the counter width can always hold.
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(LATENCY - 1)) begin
                    if (w_free) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_free) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    tnn_result_reg #(
        .PRED_W(PRED_W)
    ) u_result_reg (
        .clk          (clk),
        .rst          (rst),
        .i_capture    (w_capture),
        .i_pred       (core_prediction),
        .i_out_ready  (out_ready),
        .o_valid      (out_valid),
        .o_pred       (out_pred),
        .o_infer_count(infer_count),
        .o_free_c     (w_free)
    );

    assign in_ready  = r_in_ready;
    assign core_rst  = r_core_rst;
    assign busy      = r_busy;
    assign core_data = r_core_data;

endmodule

// File: tb/tb_tnn_infer_sequencer.sv
// Bench for tnn_infer_sequencer with a behavioural TNN core stand-in whose
// prediction is only correct once the core has run for its full latency.
module tb_tnn_infer_sequencer;

    localparam int unsigned FEAT_CNT   = 12;
    localparam int unsigned HIDDEN_CNT = 40;
    localparam int unsigned FEAT_BITS  = 4;
    localparam int unsigned CLASS_CNT  = 6;
    localparam int unsigned PRED_W     = 3;
    localparam int unsigned DW         = FEAT_BITS * FEAT_CNT;
    localparam int          LAT        = FEAT_CNT + HIDDEN_CNT;
    localparam int          SPACING    = LAT + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [DW-1:0]     core_data;
    logic              core_rst;
    logic [PRED_W-1:0] core_prediction;
    logic              out_valid;
    logic              out_ready;
    logic [PRED_W-1:0] out_pred;
    logic              busy;
    logic [15:0]       infer_count;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_count = '0;
    int          core_cyc  = 0;

    always #5 clk = ~clk;

    tnn_infer_sequencer #(
        .FEAT_CNT  (FEAT_CNT),
        .HIDDEN_CNT(HIDDEN_CNT),
        .FEAT_BITS (FEAT_BITS),
        .CLASS_CNT (CLASS_CNT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .core_data      (core_data),
        .core_rst       (core_rst),
        .core_prediction(core_prediction),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pred       (out_pred),
        .busy           (busy),
        .infer_count    (infer_count)
    );

    // Reference classifier: weighted feature sum modulo the class count.
    function automatic logic [PRED_W-1:0] ref_pred(input logic [DW-1:0] d);
        int s = 0;
        for (int i = 0; i < FEAT_CNT; i++) s += int'(d[i*FEAT_BITS +: FEAT_BITS]) * (i + 1);
        return PRED_W'(s % CLASS_CNT);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    always @(posedge clk) begin
        if (core_rst) core_cyc <= 0;
        else if (core_cyc < 100000) core_cyc <= core_cyc + 1;
    end

    // Wrong class until the core has had LAT cycles out of restart.
    assign core_prediction = (core_cyc >= LAT - 1) ? ref_pred(core_data)
                           : PRED_W'((int'(ref_pred(core_data)) + 1) % CLASS_CNT);

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
        n_chk++; if (core_rst !== 1'b1) $display("FAIL rst_core_rst got %b want 1", core_rst); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (out_pred !== '0) $display("FAIL rst_out_pred got %h want 0", out_pred); else n_pass++;
        n_chk++; if (infer_count !== 16'h0) $display("FAIL rst_count got %h want 0", infer_count); else n_pass++;
        n_chk++; if (core_data !== '0) $display("FAIL rst_core_data got %h want 0", core_data); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL rel_in_ready_early got %b want 0", in_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %b want 1", in_ready); else n_pass++;
        n_chk++; if (core_rst !== 1'b0) $display("FAIL idle_core_rst got %b want 0", core_rst); else n_pass++;
        exp_count = '0;
    endtask

    task automatic test_single();
        logic [DW-1:0] d = 48'h123456789ABC;
        out_ready = 1'b1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL single_ready got %b want 1", in_ready); else n_pass++;
        in_valid = 1'b1; in_data = d;
        for (int c = 1; c <= SPACING; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = rand_data();
            n_chk++; if (core_rst !== (c == 1)) $display("FAIL single_core_rst c=%0d got %b", c, core_rst); else n_pass++;
            n_chk++; if (out_valid !== (c == SPACING)) $display("FAIL single_out_valid c=%0d got %b", c, out_valid); else n_pass++;
            n_chk++; if (core_data !== d) $display("FAIL single_core_data c=%0d got %h want %h", c, core_data, d); else n_pass++;
        end
        exp_count++;
        n_chk++; if (out_pred !== ref_pred(d)) $display("FAIL single_pred got %0d want %0d", out_pred, ref_pred(d)); else n_pass++;
        n_chk++; if (infer_count !== exp_count) $display("FAIL single_count got %0d want %0d", infer_count, exp_count); else n_pass++;
        n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL single_idle busy=%b in_ready=%b want 0/1", busy, in_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL single_consumed got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] a = rand_data();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a;
        repeat (SPACING) begin @(negedge clk); in_valid = 1'b0; end
        n_chk++; if (out_valid !== 1'b1) $display("FAIL rmid_pending got %b want 1", out_valid); else n_pass++;
        in_valid = 1'b1; in_data = rand_data();
        @(negedge clk); in_valid = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_in_rst out_valid=%b busy=%b want 0/0", out_valid, busy); else n_pass++;
        n_chk++; if (core_rst !== 1'b1 || in_ready !== 1'b0) $display("FAIL rmid_in_rst core_rst=%b in_ready=%b want 1/0", core_rst, in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_count = '0;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", in_ready); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (infer_count !== exp_count) $display("FAIL rmid_count got %0d want %0d", infer_count, exp_count); else n_pass++;
        n_chk++; if (core_data !== '0) $display("FAIL rmid_core_data got %h want 0", core_data); else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_hold();
        logic [DW-1:0] a = rand_data();
        logic [DW-1:0] b = rand_data();
        int extra = $urandom_range(1, 20);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a;
        repeat (SPACING) begin @(negedge clk); in_valid = 1'b0; end
        exp_count++;
        n_chk++; if (out_valid !== 1'b1 || out_pred !== ref_pred(a)) $display("FAIL hold_first valid=%b pred=%0d want 1/%0d", out_valid, out_pred, ref_pred(a)); else n_pass++;
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
        repeat (SPACING - 1 + extra) begin
            in_valid = 1'b1; in_data = rand_data();
            @(negedge clk);
        end
        n_chk++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL hold_state busy=%b in_ready=%b want 1/0", busy, in_ready); else n_pass++;
        n_chk++; if (out_pred !== ref_pred(a)) $display("FAIL hold_keep_pred got %0d want %0d", out_pred, ref_pred(a)); else n_pass++;
        n_chk++; if (core_data !== b) $display("FAIL hold_core_data got %h want %h", core_data, b); else n_pass++;
        n_chk++; if (infer_count !== exp_count) $display("FAIL hold_count got %0d want %0d", infer_count, exp_count); else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        n_chk++; if (out_valid !== 1'b1 || out_pred !== ref_pred(b)) $display("FAIL hold_release valid=%b pred=%0d want 1/%0d", out_valid, out_pred, ref_pred(b)); else n_pass++;
        n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL hold_idle busy=%b in_ready=%b want 0/1", busy, in_ready); else n_pass++;
        n_chk++; if (infer_count !== exp_count) $display("FAIL hold_release_count got %0d want %0d", infer_count, exp_count); else n_pass++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL hold_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_core = core_data;
        logic [DW-1:0] pend = '0;
        logic [DW-1:0] head;
        bit  pend_v = 0;
        int  cyc = 0, prev = -1, sent = 0, got = 0;
        int  bad_core = 0, bad_gap = 0, bad_pred = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (got < 1000 && cyc < 60000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (pend_v) begin exp_core = pend; pend_v = 0; end
            n_chk++; if (core_data !== exp_core) begin bad_core++; if (bad_core < 5) $display("FAIL b2b_core_data cyc=%0d got %h want %h", cyc, core_data, exp_core); end else n_pass++;
            if (out_valid) begin
                got++;
                exp_count++;
                if (q.size() == 0) begin
                    n_chk++; $display("FAIL b2b_extra_result cyc=%0d got pred %0d want none", cyc, out_pred);
                end else begin
                    head = q.pop_front();
                    n_chk++; if (out_pred !== ref_pred(head)) begin bad_pred++; if (bad_pred < 5) $display("FAIL b2b_pred #%0d got %0d want %0d", got, out_pred, ref_pred(head)); end else n_pass++;
                end
            end
            in_data = rand_data();
            if (sent == 1000) begin
                in_valid = 1'b0;
            end else if (in_ready) begin
                if (prev >= 0) begin
                    n_chk++; if (cyc - prev != SPACING) begin bad_gap++; if (bad_gap < 5) $display("FAIL b2b_gap got %0d want %0d", cyc - prev, SPACING); end else n_pass++;
                end
                prev = cyc;
                q.push_back(in_data);
                pend = in_data; pend_v = 1;
                sent++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (got !== 1000) $display("FAIL b2b_results got %0d want 1000", got); else n_pass++;
        n_chk++; if (sent !== 1000) $display("FAIL b2b_sent got %0d want 1000", sent); else n_pass++;
        n_chk++; if (infer_count !== exp_count) $display("FAIL b2b_count got %0d want %0d", infer_count, exp_count); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_dup got out_valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d = rand_data();
        force dut.u_result_reg.r_infer_count = 16'hFFFF;
        @(negedge clk);
        release dut.u_result_reg.r_infer_count;
        @(negedge clk);
        exp_count = 16'hFFFF;
        n_chk++; if (infer_count !== exp_count) $display("FAIL wrap_preload got %h want %h", infer_count, exp_count); else n_pass++;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d;
        repeat (SPACING) begin @(negedge clk); in_valid = 1'b0; end
        exp_count++;
        n_chk++; if (infer_count !== exp_count) $display("FAIL wrap_count got %h want %h", infer_count, exp_count); else n_pass++;
        n_chk++; if (out_valid !== 1'b1 || out_pred !== ref_pred(d)) $display("FAIL wrap_pred valid=%b pred=%0d want 1/%0d", out_valid, out_pred, ref_pred(d)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tnn_infer_sequencer.md
TNN_INFER_SEQUENCER -- requirements
Module: tnn_infer_sequencer

Interface
REQ-001 Parameter FEAT_CNT, default 12: number of input features per sample.
REQ-002 Parameter HIDDEN_CNT, default 40: number of hidden neurons in the sequenced TNN core.
REQ-003 Parameter FEAT_BITS, default 4: bits per feature.
REQ-004 Parameter CLASS_CNT, default 6: number of output classes; PRED_W = $clog2(CLASS_CNT).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  host offers a sample.
REQ-008 in_ready  out  1  sequencer accepts a sample this cycle.
REQ-009 in_data  in  FEAT_BITS*FEAT_CNT  packed sample.
REQ-010 core_data  out  FEAT_BITS*FEAT_CNT  latched sample driven to the TNN core; stable for the whole inference.
REQ-011 core_rst  out  1  restart strobe to the TNN core, active-high.
REQ-012 core_prediction  in  PRED_W  class index from the TNN core.
REQ-013 out_valid  out  1  result register holds an unconsumed prediction.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_pred  out  PRED_W  captured prediction.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 infer_count  out  16  completed inferences; wraps 0xFFFF -> 0x0000.

Function
REQ-018 LATENCY SHALL equal FEAT_CNT+HIDDEN_CNT: core cycles from the first cycle with core_rst low until core_prediction is valid.
REQ-019 The FSM SHALL have the states IDLE, CLEAR, RUN and HOLD.
REQ-020 IDLE: in_ready=1; a handshake (in_valid & in_ready) SHALL latch in_data into core_data and transition to CLEAR.
REQ-021 CLEAR: core_rst=1 for exactly one cycle; cycle counter loaded with 0; SHALL transition to RUN.
REQ-022 RUN: core_rst=0; counter increments each cycle; in the cycle where the counter equals LATENCY-1, the FSM SHALL capture the result if the result register is free (out_valid=0 or out_ready=1 in that cycle), then go to IDLE; otherwise it SHALL go to HOLD.
REQ-023 HOLD: core_rst=0 and core_data held; the FSM SHALL capture core_prediction and go to IDLE in the first cycle where out_valid=0 or out_ready=1.
REQ-024 Capture SHALL load out_pred, set out_valid=1 and increment infer_count in that same cycle.
REQ-025 Handshake out_valid & out_ready without a simultaneous capture SHALL clear out_valid on the next edge; a simultaneous capture SHALL keep out_valid=1 with the new value.
REQ-026 in_ready SHALL be 0 in CLEAR, RUN and HOLD; back-to-back samples SHALL therefore be spaced at least LATENCY+2 cycles apart.
REQ-027 core_data SHALL change only on an input handshake.
REQ-028 The cycle counter SHALL be $clog2(LATENCY+1) bits wide and SHALL never wrap within RUN.
REQ-029 in_valid in CLEAR, RUN or HOLD SHALL be ignored; in_data need not be held by the host beyond the handshake cycle.

Reset
REQ-030 While rst=1: state=IDLE, counter=0, core_data=0, core_rst=1, out_valid=0, out_pred=0, infer_count=0, busy=0, in_ready=0.
REQ-031 in_ready SHALL go to 1 on the first clk edge after rst deasserts; core_rst SHALL be 0 in IDLE.
REQ-032 Reset asserted mid-inference or in HOLD SHALL abort without a capture; a pending result SHALL be discarded.

Structure
REQ-033 The shared package SHALL hold the FSM state enum, LATENCY and PRED_W derivation, and infer_count width (16).
REQ-034 The sequencer SHALL be a single module; it SHALL NOT instantiate the TNN core, which the top level connects through core_* ports.
REQ-035 One natural sub-module SHALL be tnn_result_reg, containing out_pred, out_valid and the capture/consume logic.

Verification
REQ-036 Single sample 0x123456789ABC accepted at cycle 0 -> core_rst=1 at cycle 1 only; with out_ready=1, out_pred equals the core's prediction and out_valid=1 from cycle 54; infer_count=1.
REQ-037 out_ready held 0 with a first result pending; second sample accepted -> after RUN the FSM stays in HOLD with busy=1 and in_ready=0; raising out_ready -> capture in the same cycle, out_valid stays 1 with the second prediction.
REQ-038 in_valid held high continuously with out_ready=1 over 1000 samples -> handshakes exactly 54 cycles apart; infer_count=1000; no prediction dropped or duplicated.
REQ-039 rst pulsed at counter=20 in RUN -> out_valid=0, infer_count unchanged (0), in_ready=1 on the first edge after release.
REQ-040 infer_count preloaded via 65535 completions -> next capture yields 0x0000.
REQ-041 in_data changed during RUN -> core_data unchanged until the next IDLE handshake.
